// File: rtl/for_input.sv
// Chunk distributor: buffers one input set and hands fixed-size chunks to ready multiplier sets.
// Optional zero-bubble shadow buffer enabled with `define FOR_INPUT_PREFETCH_EN.
module for_input #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_OF_MUL     = 14,
  parameter int DATA_OF_SET    = 128,
  parameter int OUT_NUM_OF_SET = 3
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [DATA_OF_SET*DATA_WIDTH-1:0]              din,
  input  logic                                           din_valid,
  output logic                                           din_ready,
  input  logic [OUT_NUM_OF_SET-1:0]                      mul_ready,
  output logic [NUM_OF_MUL*OUT_NUM_OF_SET*DATA_WIDTH-1:0] din_tmp,
  output logic [OUT_NUM_OF_SET-1:0]                      mul_valid,
  output logic [OUT_NUM_OF_SET-1:0]                      set_last
);

  localparam int NUM_CHUNK = (DATA_OF_SET + NUM_OF_MUL - 1) / NUM_OF_MUL;
  localparam int PAD       = NUM_CHUNK * NUM_OF_MUL;
  localparam int PW        = $clog2(NUM_CHUNK + 1);
  localparam int SET_BITS  = DATA_OF_SET * DATA_WIDTH;
  localparam int CHK_BITS  = NUM_OF_MUL * DATA_WIDTH;
  localparam int OUT_BITS  = CHK_BITS * OUT_NUM_OF_SET;

  typedef enum logic {
    IDLE,
    DIST
  } state_t;

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic [SET_BITS-1:0]     buf_q;
  logic [PAD*DATA_WIDTH-1:0] pad;

  logic [OUT_NUM_OF_SET-1:0] grant;
  logic [OUT_NUM_OF_SET-1:0] last_n;
  logic [OUT_BITS-1:0]       tmp_n;
  logic [PW-1:0]             ptr_n;
  logic                      final_n;

`ifdef FOR_INPUT_PREFETCH_EN
  logic [SET_BITS-1:0] shadow;
  logic                shadow_full;
  logic                take;
  assign take = din_valid && din_ready;
`endif

  // The tail of the last chunk reads as zero past the end of the set.
  always_comb begin
    pad = '0;
    pad[SET_BITS-1:0] = buf_q;
  end

  // Ready sets take consecutive chunks in ascending set order.
  always_comb begin
    grant  = '0;
    last_n = '0;
    tmp_n  = '0;
    ptr_n  = ptr;
    for (int s = 0; s < OUT_NUM_OF_SET; s++) begin
      if (state == DIST && mul_ready[s] &&
          int'(ptr_n) < NUM_CHUNK) begin
        grant[s]  = 1'b1;
        last_n[s] = int'(ptr_n) == NUM_CHUNK - 1;
        tmp_n[s*CHK_BITS +: CHK_BITS] =
          pad[int'(ptr_n)*CHK_BITS +: CHK_BITS];
        ptr_n = ptr_n + PW'(1);
      end
    end
    final_n = |grant && int'(ptr_n) == NUM_CHUNK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      buf_q     <= '0;
      din_ready <= 1'b0;
      mul_valid <= '0;
      set_last  <= '0;
      din_tmp   <= '0;
`ifdef FOR_INPUT_PREFETCH_EN
      shadow      <= '0;
      shadow_full <= 1'b0;
`endif
    end else begin
      mul_valid <= grant;
      set_last  <= last_n;
      din_tmp   <= tmp_n;
      unique case (state)
        IDLE: begin
          din_ready <= 1'b1;
          if (din_valid && din_ready) begin
            buf_q <= din;
            ptr   <= '0;
            state <= DIST;
`ifdef FOR_INPUT_PREFETCH_EN
            din_ready <= 1'b1;
`else
            din_ready <= 1'b0;
`endif
          end
        end
        DIST: begin
          ptr <= ptr_n;
`ifdef FOR_INPUT_PREFETCH_EN
          if (final_n) begin
            din_ready <= 1'b1;
            if (shadow_full) begin
              buf_q       <= shadow;
              ptr         <= '0;
              shadow_full <= 1'b0;
            end else if (take) begin
              buf_q <= din;
              ptr   <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (take) begin
            shadow      <= din;
            shadow_full <= 1'b1;
            din_ready   <= 1'b0;
          end else begin
            din_ready <= !shadow_full;
          end
`else
          din_ready <= final_n;
          if (final_n) state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_for_input.sv
// Self-checking bench for for_input: random data and grant patterns
// against a queue-of-chunks reference model.
module tb_for_input;

  localparam int DW = 32;
  localparam int NM = 14;
  localparam int DS = 128;
  localparam int NS = 3;
  localparam int NC = (DS + NM - 1) / NM;
`ifdef FOR_INPUT_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic [DS*DW-1:0]      din;
  logic                  din_valid;
  logic                  din_ready;
  logic [NS-1:0]         mul_ready;
  logic [NM*NS*DW-1:0]   din_tmp;
  logic [NS-1:0]         mul_valid;
  logic [NS-1:0]         set_last;

  for_input #(
    .DATA_WIDTH(DW),
    .NUM_OF_MUL(NM),
    .DATA_OF_SET(DS),
    .OUT_NUM_OF_SET(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .mul_ready(mul_ready),
    .din_tmp(din_tmp),
    .mul_valid(mul_valid),
    .set_last(set_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending chunks as (set_sel*16 + chunk) entries.
  logic [DW-1:0]       words [2][DS];
  int                  q[$];
  bit                  shadow_m;
  logic [NS-1:0]       exp_valid;
  logic [NS-1:0]       exp_last;
  logic [NM*NS*DW-1:0] exp_tmp;
  logic                exp_ready;

  function automatic void model_step(input logic [NS-1:0] mr);
    int e, sel, c, k;
    exp_valid = '0;
    exp_last  = '0;
    exp_tmp   = '0;
    for (int s = 0; s < NS; s++) begin
      if (mr[s] && q.size() > 0) begin
        e   = q.pop_front();
        sel = e / 16;
        c   = e % 16;
        exp_valid[s] = 1'b1;
        exp_last[s]  = (c == NC - 1);
        for (int w = 0; w < NM; w++) begin
          k = c * NM + w;
          if (k < DS) exp_tmp[(s*NM+w)*DW +: DW] = words[sel][k];
        end
      end
    end
    if (q.size() == 0 && shadow_m) begin
      for (int i = 0; i < NC; i++) q.push_back(16 + i);
      shadow_m = 1'b0;
    end
    if (q.size() == 0) exp_ready = 1'b1;
    else exp_ready = PF ? !shadow_m : 1'b0;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < NM * NS; i++)
      if (din_tmp[i*DW +: DW] !== exp_tmp[i*DW +: DW]) return i;
    return 0;
  endfunction

  function automatic void fill_set(input int sel, input bit rnd);
    for (int k = 0; k < DS; k++)
      words[sel][k] = rnd ? DW'($urandom) : DW'(k + 1);
  endfunction

  task automatic load_set(input int sel);
    int i;
    for (int k = 0; k < DS; k++) din[k*DW +: DW] = words[sel][k];
    i = 0;
    while (din_ready !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (din_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_set: din_ready got %b exp 1 within 20 cycles",
               din_ready);
    end
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    q.delete();
    for (int c = 0; c < NC; c++) q.push_back(sel * 16 + c);
  endtask

  task automatic test_reset();
    #3;
    n_checks += 4;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset din_ready got %b exp 0", din_ready);
    end
    if (mul_valid !== '0) begin
      n_fail++;
      $display("FAIL reset mul_valid got %b exp 000", mul_valid);
    end
    if (set_last !== '0) begin
      n_fail++;
      $display("FAIL reset set_last got %b exp 000", set_last);
    end
    if (din_tmp !== '0) begin
      n_fail++;
      $display("FAIL reset din_tmp got nonzero exp 0");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release din_ready got %b exp 0", din_ready);
    end
    @(negedge clk);
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_edge din_ready got %b exp 1", din_ready);
    end
  endtask

  task automatic test_full_ready();
    int d;
    fill_set(0, 1'b0);
    load_set(0);
    for (int i = 0; i < 5; i++) begin
      mul_ready = 3'b111;
      @(negedge clk);
      model_step(3'b111);
      n_checks += 4;
      if (mul_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL full[%0d] mul_valid got %b exp %b", i, mul_valid, exp_valid);
      end
      if (set_last !== exp_last) begin
        n_fail++;
        $display("FAIL full[%0d] set_last got %b exp %b", i, set_last, exp_last);
      end
      if (din_tmp !== exp_tmp) begin
        n_fail++;
        d = first_diff();
        $display("FAIL full[%0d] din_tmp word %0d got %h exp %h", i, d,
                 din_tmp[d*DW +: DW], exp_tmp[d*DW +: DW]);
      end
      if (din_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL full[%0d] din_ready got %b exp %b", i, din_ready, exp_ready);
      end
    end
    mul_ready = '0;
  endtask

  task automatic test_pattern();
    logic [NS-1:0] pat [8];
    int d;
    pat = '{3'b101, 3'b010, 3'b111, 3'b100, 3'b100, 3'b100, 3'b100, 3'b111};
    fill_set(0, 1'b1);
    load_set(0);
    for (int i = 0; i < 8; i++) begin
      mul_ready = pat[i];
      @(negedge clk);
      model_step(pat[i]);
      n_checks += 4;
      if (mul_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL pattern[%0d] mul_valid got %b exp %b", i, mul_valid, exp_valid);
      end
      if (set_last !== exp_last) begin
        n_fail++;
        $display("FAIL pattern[%0d] set_last got %b exp %b", i, set_last, exp_last);
      end
      if (din_tmp !== exp_tmp) begin
        n_fail++;
        d = first_diff();
        $display("FAIL pattern[%0d] din_tmp word %0d got %h exp %h", i, d,
                 din_tmp[d*DW +: DW], exp_tmp[d*DW +: DW]);
      end
      if (din_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL pattern[%0d] din_ready got %b exp %b", i, din_ready, exp_ready);
      end
    end
    mul_ready = '0;
  endtask

  task automatic test_stall();
    logic [NS-1:0] mr;
    int d;
    fill_set(0, 1'b1);
    load_set(0);
    for (int i = 0; i < 9; i++) begin
      mr = (i < 5) ? 3'b000 : 3'b111;
      mul_ready = mr;
      @(negedge clk);
      model_step(mr);
      n_checks += 4;
      if (mul_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL stall[%0d] mul_valid got %b exp %b", i, mul_valid, exp_valid);
      end
      if (set_last !== exp_last) begin
        n_fail++;
        $display("FAIL stall[%0d] set_last got %b exp %b", i, set_last, exp_last);
      end
      if (din_tmp !== exp_tmp) begin
        n_fail++;
        d = first_diff();
        $display("FAIL stall[%0d] din_tmp word %0d got %h exp %h", i, d,
                 din_tmp[d*DW +: DW], exp_tmp[d*DW +: DW]);
      end
      if (din_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL stall[%0d] din_ready got %b exp %b", i, din_ready, exp_ready);
      end
    end
    mul_ready = '0;
  endtask

  task automatic test_random();
    logic [NS-1:0] mr;
    int cyc, d;
    for (int n = 0; n < 4; n++) begin
      fill_set(0, 1'b1);
      load_set(0);
      cyc = 0;
      while (q.size() > 0 && cyc < 200) begin
        mr = NS'($urandom_range(0, 7));
        mul_ready = mr;
        @(negedge clk);
        model_step(mr);
        n_checks += 4;
        if (mul_valid !== exp_valid) begin
          n_fail++;
          $display("FAIL random[%0d.%0d] mul_valid got %b exp %b", n, cyc,
                   mul_valid, exp_valid);
        end
        if (set_last !== exp_last) begin
          n_fail++;
          $display("FAIL random[%0d.%0d] set_last got %b exp %b", n, cyc,
                   set_last, exp_last);
        end
        if (din_tmp !== exp_tmp) begin
          n_fail++;
          d = first_diff();
          $display("FAIL random[%0d.%0d] din_tmp word %0d got %h exp %h", n, cyc,
                   d, din_tmp[d*DW +: DW], exp_tmp[d*DW +: DW]);
        end
        if (din_ready !== exp_ready) begin
          n_fail++;
          $display("FAIL random[%0d.%0d] din_ready got %b exp %b", n, cyc,
                   din_ready, exp_ready);
        end
        cyc++;
      end
      n_checks++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL random[%0d] chunks left got %0d exp 0", n, q.size());
      end
    end
    mul_ready = '0;
  endtask

  task automatic test_reset_mid();
    int d;
    fill_set(0, 1'b1);
    load_set(0);
    mul_ready = 3'b111;
    @(negedge clk);
    model_step(3'b111);
    n_checks++;
    if (mul_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL rst_mid first grant got %b exp %b", mul_valid, exp_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_checks += 4;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid din_ready got %b exp 0", din_ready);
    end
    if (mul_valid !== '0) begin
      n_fail++;
      $display("FAIL rst_mid mul_valid got %b exp 000", mul_valid);
    end
    if (set_last !== '0) begin
      n_fail++;
      $display("FAIL rst_mid set_last got %b exp 000", set_last);
    end
    if (din_tmp !== '0) begin
      n_fail++;
      $display("FAIL rst_mid din_tmp got nonzero exp 0");
    end
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    shadow_m = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid release din_ready got %b exp 1", din_ready);
    end
    if (mul_valid !== '0) begin
      n_fail++;
      $display("FAIL rst_mid release mul_valid got %b exp 000", mul_valid);
    end
    fill_set(0, 1'b1);
    load_set(0);
    for (int i = 0; i < 4; i++) begin
      mul_ready = 3'b111;
      @(negedge clk);
      model_step(3'b111);
      n_checks += 3;
      if (mul_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rst_mid_new[%0d] mul_valid got %b exp %b", i, mul_valid, exp_valid);
      end
      if (set_last !== exp_last) begin
        n_fail++;
        $display("FAIL rst_mid_new[%0d] set_last got %b exp %b", i, set_last, exp_last);
      end
      if (din_tmp !== exp_tmp) begin
        n_fail++;
        d = first_diff();
        $display("FAIL rst_mid_new[%0d] din_tmp word %0d got %h exp %h", i, d,
                 din_tmp[d*DW +: DW], exp_tmp[d*DW +: DW]);
      end
    end
    mul_ready = '0;
  endtask

`ifndef FOR_INPUT_PREFETCH_EN
  task automatic test_no_prefetch();
    int d;
    fill_set(0, 1'b1);
    fill_set(1, 1'b1);
    load_set(0);
    for (int k = 0; k < DS; k++) din[k*DW +: DW] = words[1][k];
    din_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mul_ready = 3'b111;
      @(negedge clk);
      if (i == 4) begin
        din_valid = 1'b0;
        n_checks += 2;
        if (mul_valid !== '0) begin
          n_fail++;
          $display("FAIL noprefetch capture mul_valid got %b exp 000", mul_valid);
        end
        if (din_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL noprefetch capture din_ready got %b exp 0", din_ready);
        end
        q.delete();
        for (int c = 0; c < NC; c++) q.push_back(16 + c);
      end else begin
        model_step(3'b111);
        n_checks += 3;
        if (mul_valid !== exp_valid) begin
          n_fail++;
          $display("FAIL noprefetch[%0d] mul_valid got %b exp %b", i, mul_valid, exp_valid);
        end
        if (din_tmp !== exp_tmp) begin
          n_fail++;
          d = first_diff();
          $display("FAIL noprefetch[%0d] din_tmp word %0d got %h exp %h", i, d,
                   din_tmp[d*DW +: DW], exp_tmp[d*DW +: DW]);
        end
        if (din_ready !== exp_ready) begin
          n_fail++;
          $display("FAIL noprefetch[%0d] din_ready got %b exp %b", i, din_ready, exp_ready);
        end
      end
    end
    mul_ready = '0;
  endtask
`else
  task automatic test_prefetch();
    int d;
    fill_set(0, 1'b1);
    fill_set(1, 1'b1);
    load_set(0);
    for (int k = 0; k < DS; k++) din[k*DW +: DW] = words[1][k];
    din_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mul_ready = 3'b111;
      @(negedge clk);
      if (i == 0) begin
        shadow_m  = 1'b1;
        din_valid = 1'b0;
      end
      model_step(3'b111);
      n_checks += 4;
      if (mul_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL prefetch[%0d] mul_valid got %b exp %b", i, mul_valid, exp_valid);
      end
      if (set_last !== exp_last) begin
        n_fail++;
        $display("FAIL prefetch[%0d] set_last got %b exp %b", i, set_last, exp_last);
      end
      if (din_tmp !== exp_tmp) begin
        n_fail++;
        d = first_diff();
        $display("FAIL prefetch[%0d] din_tmp word %0d got %h exp %h", i, d,
                 din_tmp[d*DW +: DW], exp_tmp[d*DW +: DW]);
      end
      if (din_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL prefetch[%0d] din_ready got %b exp %b", i, din_ready, exp_ready);
      end
    end
    mul_ready = '0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    mul_ready = '0;
    shadow_m  = 1'b0;
    test_reset();
    test_full_ready();
    test_pattern();
    test_stall();
    test_random();
    test_reset_mid();
`ifndef FOR_INPUT_PREFETCH_EN
    test_no_prefetch();
`else
    test_prefetch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
